// File: rtl/niosduino_core_pio_edge.sv
// PIO input conditioner: 2-flop sync, per-bit debounce, edge capture and irq over Avalon-MM.
// Optional debounce counters enabled by defining PIO_EDGE_DEBOUNCE_EN.
module niosduino_core_pio_edge #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DBNC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins_in,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] stable_out,
  output logic             irq
);

  localparam int unsigned DATA_W    = 32;
  localparam logic [2:0]  ADDR_DATA = 3'd0;
  localparam logic [2:0]  ADDR_MASK = 3'd2;
  localparam logic [2:0]  ADDR_EDGE = 3'd3;
  localparam logic [2:0]  ADDR_MODE = 3'd6;
  localparam logic [2:0]  ADDR_DBNC = 3'd7;
  localparam logic [1:0]  EDGE_RISE = 2'd0;
  localparam logic [1:0]  EDGE_FALL = 2'd1;
  localparam logic [1:0]  EDGE_BOTH = 2'd2;

  logic [WIDTH-1:0]  sync_q1;
  logic [WIDTH-1:0]  sync_q2;
  logic [WIDTH-1:0]  stable;
  logic [WIDTH-1:0]  stable_d;
  logic [WIDTH-1:0]  irqmask;
  logic [WIDTH-1:0]  edgecapture;
  logic [1:0]        edge_mode;
  logic              wr_en;
  logic [WIDTH-1:0]  edge_set;
  logic [WIDTH-1:0]  edge_clr;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  // Metastability guard on the asynchronous pin levels
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= pins_in;
      sync_q2 <= sync_q1;
    end
  end

`ifdef PIO_EDGE_DEBOUNCE_EN
  localparam logic [DBNC_W-1:0] CNT_MAX   = '1;
  localparam logic [DBNC_W-1:0] LIMIT_RST = DBNC_W'(255);

  logic [DBNC_W-1:0] dbnc_limit;
  logic [DBNC_W-1:0] cnt [WIDTH];

  // Per-bit debounce: stable flips once sync has disagreed for dbnc_limit+1 edges
  always_ff @(posedge clk) begin
    if (reset) begin
      dbnc_limit <= LIMIT_RST;
      stable     <= '0;
      for (int i = 0; i < int'(WIDTH); i++) cnt[i] <= '0;
    end else begin
      if (wr_en && address == ADDR_DBNC) dbnc_limit <= writedata[DBNC_W-1:0];
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync_q2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] >= dbnc_limit) begin
          stable[i] <= ~stable[i];
          cnt[i]    <= '0;
        end else if (cnt[i] != CNT_MAX) begin
          cnt[i] <= cnt[i] + DBNC_W'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) stable <= '0;
    else       stable <= sync_q2;
  end
`endif

  // Edge detection on the conditioned level, selected by edge_mode
  always_comb begin
    edge_set = '0;
    edge_clr = '0;
    case (edge_mode)
      EDGE_RISE: edge_set = stable & ~stable_d;
      EDGE_FALL: edge_set = ~stable & stable_d;
      EDGE_BOTH: edge_set = stable ^ stable_d;
      default:   edge_set = '0;
    endcase
    if (wr_en && address == ADDR_EDGE) edge_clr = writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux = DATA_W'(stable);
      ADDR_MASK: rd_mux = DATA_W'(irqmask);
      ADDR_EDGE: rd_mux = DATA_W'(edgecapture);
      ADDR_MODE: rd_mux = DATA_W'(edge_mode);
`ifdef PIO_EDGE_DEBOUNCE_EN
      ADDR_DBNC: rd_mux = DATA_W'(dbnc_limit);
`else
      ADDR_DBNC: rd_mux = DATA_W'({DBNC_W{1'b0}});
`endif
      default:   rd_mux = '0;
    endcase
  end

  // Control registers, edge capture (set beats clear) and registered read port
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d    <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
      edge_mode   <= EDGE_RISE;
      readdata    <= '0;
    end else begin
      stable_d    <= stable;
      edgecapture <= (edgecapture & ~edge_clr) | edge_set;
      readdata    <= rd_mux;
      if (wr_en && address == ADDR_MASK) irqmask   <= writedata[WIDTH-1:0];
      if (wr_en && address == ADDR_MODE) edge_mode <= writedata[1:0];
    end
  end

  assign stable_out = stable;
  assign irq        = |(edgecapture & irqmask);

endmodule
